adder_8bit_accum: RTL and testbench
===================================

// Module: adder_8bit_accum
// PURPOSE
//  Downstream consumer of the 8-bit ripple adder: takes each {cout,sum[7:0]}
//  result as a 9-bit value and accumulates N_SAMPLES of them into an ACC_W-bit total.
//  Each completed block total is held in an output register with a valid/ready handshake.
//  The upstream adder stays purely combinational; this block adds valid/ready sequencing.
// PARAMETERS
//  N_SAMPLES  4   results summed per output block (>=2)
//  ACC_W      12  accumulator/output width; overflow wraps mod 2^ACC_W and is flagged
// PORTS
//  clk        in   1      single clock, all state on rising edge
//  rst        in   1      synchronous, active-high reset
//  clear      in   1      sync: discard partial block (count and accumulator)
//  in_valid   in   1      in_sum/in_cout valid this cycle
//  in_ready   out  1      block can accept input this cycle
//  in_sum     in   8      adder sum[7:0]
//  in_cout    in   1      adder carry-out (bit 8 of the operand)
//  out_valid  out  1      out_acc/out_ovf hold a completed block
//  out_ready  in   1      consumer takes the result this cycle
//  out_acc    out  ACC_W  block total
//  out_ovf    out  1      a carry left bit ACC_W-1 at some point during the block
// BEHAVIOUR
//  - Reset: out_valid=0, out_acc=0, out_ovf=0; cnt=0; acc=0; ovf_run=0.
//  - Input fire = in_valid & in_ready; operand v = {{(ACC_W-9){1'b0}}, in_cout, in_sum}.
//  - Output fire = out_valid & out_ready.
//  - Partial-block state: cnt 0..N_SAMPLES-1; acc; sticky ovf_run.
//    * IDLE: cnt==0.
//    * ACCUM: 0<cnt<N-1.
//    * LAST: cnt==N-1.
//  - Fire in IDLE/ACCUM: acc<=acc+v (mod 2^ACC_W); ovf_run|=carry; cnt<=cnt+1.
//  - Fire in LAST:
//    * out_acc<=acc+v; out_ovf<=ovf_run|carry; out_valid<=1.
//    * acc<=0; ovf_run<=0; cnt<=0.
//  - Latency: out_valid rises the cycle after the Nth input fire.
//  - Output register: out_valid stays high and out_acc/out_ovf stay stable until output fire.
//    * Output fire with no new completion: out_valid<=0 next cycle.
//  - in_ready = ~(cnt==N-1 & out_valid & ~out_ready).
//    * Combinational path from out_ready only; in_ready is 1 in IDLE/ACCUM regardless.
//    * Simultaneous output fire and LAST input fire: new result loads, out_valid stays 1.
//  - clear: cnt/acc/ovf_run<=0; an input in the same cycle is dropped.
//    * in_ready is unaffected by clear.
//    * out_valid/out_acc/out_ovf are unaffected by clear.
//  - Priority: rst > clear > input fire. Output fire is independent of clear.
//  - rst mid-block or with a pending result discards everything; no output is produced.
//  - in_sum/in_cout are ignored when not fired; X on them must not propagate.
// STRUCTURE
//  - Shared header adder_defs.vh holds:
//    * ADDER_W=8, OPND_W=ADDER_W+1.
//    * Default ACC_W/N_SAMPLES.
//    * State encodings IDLE/ACCUM/LAST (derived from cnt; no separate state register).
//  - Count width: $clog2(N_SAMPLES).
//  - Elaboration check: ACC_W >= OPND_W.
//  - One sub-module: acc_result_reg holds out_valid/out_acc/out_ovf.
//    * Loads on completion; clears on output fire; exports the stall term for in_ready.
// TESTING
//  1. rst, then 4 fires of {1,0xFF}, out_ready=1 -> cycle after 4th: out_acc=0x7FC, out_ovf=0, out_valid for 1 cycle.
//  2. ACC_W=10, same stimulus -> out_acc=0x3FC, out_ovf=1; next block of 4x{0,0x01} -> out_acc=0x004, out_ovf=0 (sticky flag cleared).
//  3. out_ready=0, 7 back-to-back fires of {0,0x10} -> out_acc=0x040 held, cnt==3, in_ready=0; raise out_ready -> in_ready=1 same cycle, 8th fire -> out_acc=0x040 again, out_valid never drops.
//  4. 2 fires of {0,0x05}, clear with in_valid=1, then 4x{0,0x01} -> out_acc=0x004; a held result present during clear is still presented unchanged.
//  5. rst asserted after 3 fires and while out_valid=1 -> next cycle out_valid=0, out_acc=0; next 4 fires of {0,0x02} -> out_acc=0x008.
//  6. Random in_valid/out_ready, 1000 blocks -> scoreboard of sum mod 2^ACC_W and ovf matches; no result lost or duplicated; out_acc stable while out_valid & ~out_ready.

Source files
------------

// File: rtl/adder_8bit_accum_pkg.sv
// Shared definitions for the adder_8bit_accum block.
//   ADDER_W / OPND_W : upstream adder width and the {cout,sum} operand width
//   DEF_*            : default block parameters
//   phase_e          : partial-block phase, decoded from the sample count
package adder_8bit_accum_pkg;

  localparam int unsigned ADDER_W       = 8;
  localparam int unsigned OPND_W        = ADDER_W + 1;
  localparam int unsigned DEF_ACC_W     = 12;
  localparam int unsigned DEF_N_SAMPLES = 4;

  typedef enum logic [1:0] {
    PH_IDLE  = 2'd0,
    PH_ACCUM = 2'd1,
    PH_LAST  = 2'd2
  } phase_e;

  // Phase is a pure function of the count; there is no separate state register.
  function automatic phase_e phase_of(input int unsigned cnt, input int unsigned n);
    if (cnt == 0)          return PH_IDLE;
    else if (cnt == n - 1) return PH_LAST;
    else                   return PH_ACCUM;
  endfunction

endpackage

// File: rtl/adder_8bit_accum_if.sv
// Handshake bundle between the ripple adder side and the result consumer.
//   clear                      : drop the partial block
//   in_valid/in_ready          : input handshake, in_sum/in_cout payload
//   out_valid/out_ready        : output handshake, out_acc/out_ovf payload
// master = producer/consumer environment, slave = accumulator block.
interface adder_8bit_accum_if
  import adder_8bit_accum_pkg::*;
#(
  parameter int unsigned ACC_W = DEF_ACC_W
);
  logic               clear;
  logic               in_valid;
  logic               in_ready;
  logic [ADDER_W-1:0] in_sum;
  logic               in_cout;
  logic               out_valid;
  logic               out_ready;
  logic [ACC_W-1:0]   out_acc;
  logic               out_ovf;

  modport master (
    output clear, in_valid, in_sum, in_cout, out_ready,
    input  in_ready, out_valid, out_acc, out_ovf
  );

  modport slave (
    input  clear, in_valid, in_sum, in_cout, out_ready,
    output in_ready, out_valid, out_acc, out_ovf
  );
endinterface

// File: rtl/adder_8bit_accum_result_reg.sv
// Output holding register for completed block totals.
//   clk, rst   : clock, synchronous active-high reset
//   i_load     : a block completes this cycle; capture i_acc/i_ovf
//   i_acc/i_ovf: completed total and its overflow flag
//   i_ready    : consumer takes the held result this cycle
//   o_valid/o_acc/o_ovf : held result
//   o_stall    : result held and not being taken (blocks a completing input)
module acc_result_reg #(
  parameter int unsigned ACC_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [ACC_W-1:0] i_acc,
  input  logic             i_ovf,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [ACC_W-1:0] o_acc,
  output logic             o_ovf,
  output logic             o_stall
);

  logic             r_valid;
  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;

  // A load wins over an output fire in the same cycle so back-to-back
  // results keep out_valid high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_acc   <= i_acc;
      r_ovf   <= i_ovf;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_acc   = r_acc;
  assign o_ovf   = r_ovf;
  assign o_stall = r_valid & ~i_ready;

endmodule

// File: rtl/adder_8bit_accum.sv
// Accumulates N_SAMPLES 9-bit {cout,sum} adder results into an ACC_W-bit
// block total, presented through a valid/ready output register.
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset
//   bus  : slave side of adder_8bit_accum_if (clear, input and output handshakes)
module adder_8bit_accum
  import adder_8bit_accum_pkg::*;
#(
  parameter int unsigned N_SAMPLES = DEF_N_SAMPLES,
  parameter int unsigned ACC_W     = DEF_ACC_W
) (
  input  logic               clk,
  input  logic               rst,
  adder_8bit_accum_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(N_SAMPLES);

  if (ACC_W < OPND_W) begin : g_acc_w_check
    $error("adder_8bit_accum: ACC_W must be at least OPND_W");
  end
  if (N_SAMPLES < 2) begin : g_n_check
    $error("adder_8bit_accum: N_SAMPLES must be at least 2");
  end

  logic [CNT_W-1:0] r_cnt;
  logic [ACC_W-1:0] r_acc;
  logic             r_ovf_run;

  phase_e           w_phase;
  logic             w_stall;
  logic             w_in_ready;
  logic             w_take;
  logic             w_done;
  logic [ACC_W-1:0] w_opnd;
  logic [ACC_W:0]   w_sum;
  logic             w_carry;
  logic             w_out_valid;
  logic [ACC_W-1:0] w_out_acc;
  logic             w_out_ovf;

  // The operand is forced to zero unless the input is actually taken, so
  // unknown in_sum/in_cout values never reach the adder or the carry flag.
  always_comb begin
    w_phase    = phase_of(32'(r_cnt), N_SAMPLES);
    w_in_ready = ~((w_phase == PH_LAST) & w_stall);
    w_take     = bus.in_valid & w_in_ready & ~bus.clear;
    w_done     = w_take & (w_phase == PH_LAST);
    w_opnd     = '0;
    if (w_take) begin
      w_opnd = ACC_W'({bus.in_cout, bus.in_sum});
    end
    w_sum   = {1'b0, r_acc} + {1'b0, w_opnd};
    w_carry = w_sum[ACC_W];
  end

  always_ff @(posedge clk) begin
    if (rst || bus.clear) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_ovf_run <= 1'b0;
    end else if (w_take) begin
      if (w_done) begin
        r_cnt     <= '0;
        r_acc     <= '0;
        r_ovf_run <= 1'b0;
      end else begin
        r_cnt     <= r_cnt + 1'b1;
        r_acc     <= w_sum[ACC_W-1:0];
        r_ovf_run <= r_ovf_run | w_carry;
      end
    end
  end

  acc_result_reg #(
    .ACC_W (ACC_W)
  ) u_result (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_done),
    .i_acc   (w_sum[ACC_W-1:0]),
    .i_ovf   (r_ovf_run | w_carry),
    .i_ready (bus.out_ready),
    .o_valid (w_out_valid),
    .o_acc   (w_out_acc),
    .o_ovf   (w_out_ovf),
    .o_stall (w_stall)
  );

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_acc   = w_out_acc;
  assign bus.out_ovf   = w_out_ovf;

endmodule

// File: tb/tb_adder_8bit_accum.sv
// Bench for adder_8bit_accum: two instances (ACC_W=12 and ACC_W=10) share
// one stimulus stream; expected block results are queued when a block is
// issued and a monitor pops them on every output fire.
module tb_adder_8bit_accum;
  import adder_8bit_accum_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_cout = 1'b0;
  logic [7:0] in_sum = 8'h00;
  logic       out_ready = 1'b0;
  logic       rnd_on = 1'b0;

  int total = 0;
  int bad   = 0;

  logic [12:0] qa[$];  // {ovf, acc[11:0]}
  logic [10:0] qb[$];  // {ovf, acc[9:0]}

  always #5 clk = ~clk;

  adder_8bit_accum_if #(.ACC_W(12)) ia ();
  adder_8bit_accum_if #(.ACC_W(10)) ib ();

  assign ia.clear = clear;  assign ib.clear = clear;
  assign ia.in_valid = in_valid;  assign ib.in_valid = in_valid;
  assign ia.in_cout = in_cout;  assign ib.in_cout = in_cout;
  assign ia.in_sum = in_sum;  assign ib.in_sum = in_sum;
  assign ia.out_ready = out_ready;  assign ib.out_ready = out_ready;

  adder_8bit_accum #(.N_SAMPLES(4), .ACC_W(12)) u_dut_a (.clk(clk), .rst(rst), .bus(ia));
  adder_8bit_accum #(.N_SAMPLES(4), .ACC_W(10)) u_dut_b (.clk(clk), .rst(rst), .bus(ib));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic expect_pair(input logic [11:0] a, input logic ao,
                             input logic [9:0] b, input logic bo);
    qa.push_back({ao, a});
    qb.push_back({bo, b});
  endtask

  // Called at posedge+1; returns at posedge+1 right after the input fired.
  task automatic drive(input logic c, input logic [7:0] s);
    int unsigned n;
    n = 0;
    in_valid = 1'b1;
    in_cout  = c;
    in_sum   = s;
    @(negedge clk);
    while (!ia.in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!ia.in_ready) begin
      total++;
      bad++;
      $display("FAIL in_ready_timeout: got 0 want 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_cout  = 1'b1;
    in_sum   = 8'hA5;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor: pops on output fire, and checks the held result is stable
  // across stalled cycles.
  initial begin : monitor
    logic [12:0] ea;
    logic [10:0] eb;
    logic        prev_stall;
    logic [12:0] prev_a;
    prev_stall = 1'b0;
    prev_a     = '0;
    forever begin
      @(negedge clk);
      if (prev_stall && ia.out_valid)
        check("stable_a", 32'({ia.out_ovf, ia.out_acc}), 32'(prev_a));
      if (ia.out_valid && out_ready) begin
        if (qa.size() == 0) begin
          total++; bad++;
          $display("FAIL extra_a: got %0h want none", ia.out_acc);
        end else begin
          ea = qa.pop_front();
          check("acc_a", 32'(ia.out_acc), 32'(ea[11:0]));
          check("ovf_a", 32'(ia.out_ovf), 32'(ea[12]));
        end
      end
      if (ib.out_valid && out_ready) begin
        if (qb.size() == 0) begin
          total++; bad++;
          $display("FAIL extra_b: got %0h want none", ib.out_acc);
        end else begin
          eb = qb.pop_front();
          check("acc_b", 32'(ib.out_acc), 32'(eb[9:0]));
          check("ovf_b", 32'(ib.out_ovf), 32'(eb[10]));
        end
      end
      prev_stall = ia.out_valid & ~out_ready;
      prev_a     = {ia.out_ovf, ia.out_acc};
    end
  end

  initial begin : rnd_ready
    forever begin
      @(posedge clk); #1;
      if (rnd_on) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: got timeout want finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int unsigned tot;
    logic        c;
    logic [7:0]  s;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(ia.out_valid), 32'd0);
    check("rst_out_acc", 32'(ia.out_acc), 32'd0);
    check("rst_out_ovf", 32'(ia.out_ovf), 32'd0);
    check("rst_in_ready", 32'(ia.in_ready), 32'd1);
    @(posedge clk); #1;

    // 1 and 2: 4 x 0x1FF wraps for ACC_W=10; next block clears the sticky flag
    out_ready = 1'b1;
    expect_pair(12'h7FC, 1'b0, 10'h3FC, 1'b1);
    repeat (4) drive(1'b1, 8'hFF);
    @(negedge clk);
    check("latency_valid", 32'(ia.out_valid), 32'd1);
    @(negedge clk);
    check("valid_one_cycle", 32'(ia.out_valid), 32'd0);
    @(posedge clk); #1;
    expect_pair(12'h004, 1'b0, 10'h004, 1'b0);
    repeat (4) drive(1'b0, 8'h01);
    idle(2);

    // 3: back-pressure with a full second block waiting on the held result
    out_ready = 1'b0;
    expect_pair(12'h040, 1'b0, 10'h040, 1'b0);
    expect_pair(12'h040, 1'b0, 10'h040, 1'b0);
    repeat (7) drive(1'b0, 8'h10);
    in_valid = 1'b1;
    in_cout  = 1'b0;
    in_sum   = 8'h10;
    @(negedge clk);
    check("bp_in_ready", 32'(ia.in_ready), 32'd0);
    check("bp_out_acc", 32'(ia.out_acc), 32'h040);
    check("bp_out_valid", 32'(ia.out_valid), 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    #1;
    check("bp_ready_comb", 32'(ia.in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_valid_kept", 32'(ia.out_valid), 32'd1);
    check("bp_acc_again", 32'(ia.out_acc), 32'h040);
    @(posedge clk); #1;
    idle(2);

    // 4: clear drops the partial block and its same-cycle input only
    out_ready = 1'b0;
    expect_pair(12'h00C, 1'b0, 10'h00C, 1'b0);
    repeat (4) drive(1'b0, 8'h03);
    repeat (2) drive(1'b0, 8'h05);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_cout  = 1'b0;
    in_sum   = 8'h05;
    @(negedge clk);
    check("clr_in_ready", 32'(ia.in_ready), 32'd1);
    @(posedge clk); #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("clr_held_valid", 32'(ia.out_valid), 32'd1);
    check("clr_held_acc", 32'(ia.out_acc), 32'h00C);
    @(posedge clk); #1;
    out_ready = 1'b1;
    expect_pair(12'h004, 1'b0, 10'h004, 1'b0);
    repeat (4) drive(1'b0, 8'h01);
    idle(3);

    // 5: reset with a held result and a partial block discards both
    out_ready = 1'b0;
    repeat (4) drive(1'b0, 8'h01);
    repeat (3) drive(1'b0, 8'h07);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 32'(ia.out_valid), 32'd0);
    check("mid_rst_acc", 32'(ia.out_acc), 32'd0);
    check("mid_rst_ovf", 32'(ia.out_ovf), 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    expect_pair(12'h008, 1'b0, 10'h008, 1'b0);
    repeat (4) drive(1'b0, 8'h02);
    idle(3);

    // 6: random gaps and back-pressure over 1000 blocks
    rnd_on = 1'b1;
    for (int unsigned blk = 0; blk < 1000; blk++) begin
      logic [8:0] v[4];
      tot = 0;
      for (int unsigned k = 0; k < 4; k++) begin
        c = 1'($urandom_range(0, 1));
        s = 8'($urandom_range(0, 255));
        v[k] = {c, s};
        tot += int'(v[k]);
      end
      expect_pair(12'(tot), tot >= 4096, 10'(tot), tot >= 1024);
      for (int unsigned k = 0; k < 4; k++) begin
        if ($urandom_range(0, 3) == 0) idle(1);
        drive(v[k][8], v[k][7:0]);
      end
    end
    rnd_on = 1'b0;
    out_ready = 1'b1;
    for (int unsigned i = 0; i < 50 && (qa.size() != 0 || qb.size() != 0); i++) begin
      @(posedge clk); #1;
    end
    idle(2);
    check("drain_a", 32'(qa.size()), 32'd0);
    check("drain_b", 32'(qb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
